score_award_sequencer: RTL and testbench

Controller that sits between the game logic and the cascaded 7-segment digit counters. It accepts point awards from two requesters: the frog-home event and the bonus timer. A fixed-priority arbiter chooses between them, and the awards are converted into a paced train of single-cycle point pulses into the least-significant digit counter. It keeps a BCD shadow of the displayed score so it can saturate at 999 instead of letting the digit chain wrap, and it tracks a high score across games.

---
 rtl/score_award_sequencer_if.sv | 33 +++
 rtl/score_award_sequencer.sv | 169 ++++++++++++++++
 tb/tb_score_award_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/score_award_sequencer_if.sv
// Award handshake bundle between the two point requesters (frog-home and
// bonus timer) and the score award sequencer. Each requester holds its
// request level and amount stable until it sees its one-cycle ack.
interface score_award_sequencer_if #(
    parameter int AMT_W = 4
);
    logic             home_req;
    logic [AMT_W-1:0] home_amt;
    logic             home_ack;
    logic             bonus_req;
    logic [AMT_W-1:0] bonus_amt;
    logic             bonus_ack;

    // Requester side: drives requests and amounts, watches for acks.
    modport master (
        output home_req,
        output home_amt,
        input  home_ack,
        output bonus_req,
        output bonus_amt,
        input  bonus_ack
    );

    // Sequencer side: sees requests and amounts, returns acks.
    modport slave (
        input  home_req,
        input  home_amt,
        output home_ack,
        input  bonus_req,
        input  bonus_amt,
        output bonus_ack
    );
endinterface

// File: rtl/score_award_sequencer.sv
// Score award sequencer: arbitrates point awards from the frog-home event and
// the bonus timer, queues them in a pending accumulator, and replays them as a
// paced train of single-cycle pulses into the ones-digit counter. A BCD shadow
// of the displayed score lets the train stop at 999 instead of letting the
// digit chain wrap, and the high score is tracked across games.
module score_award_sequencer #(
    parameter int AMT_W  = 4,
    parameter int PEND_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    score_award_sequencer_if.slave       awards,
    output logic                         point,
    output logic                         busy,
    output logic [11:0]                  score_bcd,
    output logic                         saturated,
    output logic [11:0]                  hi_bcd,
    output logic                         new_high
);

    // One extra bit so the acceptance check can see an overflow of the
    // pending accumulator before it happens.
    localparam int SUM_W = PEND_W + 1;
    localparam logic [11:0] SCORE_MAX = 12'h999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [PEND_W-1:0]  pending;

    logic               hold;
    logic               any_req;
    logic [AMT_W-1:0]   win_amt;
    logic [SUM_W-1:0]   trial_sum;
    logic               fits;
    logic               accept;
    logic [AMT_W-1:0]   added_amt;
    logic [SUM_W-1:0]   next_sum;
    logic [PEND_W-1:0]  pending_next;
    logic [11:0]        score_inc;

    // Increment a three-digit BCD value with digit carry; 9 rolls to 0 and
    // carries into the next digit up.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        logic [3:0] hund;
        ones = v[3:0];
        tens = v[7:4];
        hund = v[11:8];
        if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
                hund = (hund == 4'd9) ? 4'd0 : hund + 4'd1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {hund, tens, ones};
    endfunction

    // Fixed-priority arbitration and acceptance: home beats bonus, and a
    // request is only taken if the pending accumulator can absorb it after
    // this cycle's pulse (if any) has been subtracted. Reset and clear block
    // every ack so nothing slips in while the game is being cleared.
    always_comb begin
        hold      = reset | clear;
        any_req   = awards.home_req | awards.bonus_req;
        win_amt   = awards.home_req ? awards.home_amt : awards.bonus_amt;
        trial_sum = SUM_W'(pending) + SUM_W'(win_amt) - SUM_W'(point);
        fits      = (trial_sum[SUM_W-1] == 1'b0);
        accept    = ~hold & any_req & fits;

        awards.home_ack  = accept & awards.home_req;
        awards.bonus_ack = accept & ~awards.home_req & awards.bonus_req;

        // Once the score is pinned at 999, accepted points are thrown away.
        added_amt    = (accept & ~saturated) ? win_amt : '0;
        next_sum     = SUM_W'(pending) + SUM_W'(added_amt) - SUM_W'(point);
        pending_next = next_sum[PEND_W-1:0];

        score_inc = bcd_inc(score_bcd);
    end

    // Pulse-train state machine with registered outputs. PULSE always falls
    // into GAP so pulses are never back to back; GAP is also where a pinned
    // score drops whatever points are still queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            point     <= 1'b0;
            busy      <= 1'b0;
            score_bcd <= '0;
            saturated <= 1'b0;
            hi_bcd    <= '0;
            new_high  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            pending   <= '0;
            point     <= 1'b0;
            busy      <= 1'b0;
            score_bcd <= '0;
            saturated <= 1'b0;
            new_high  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pending <= pending_next;
                    busy    <= (pending_next != '0);
                    if ((pending_next != '0) && !saturated) begin
                        state <= PULSE;
                        point <= 1'b1;
                    end else begin
                        state <= IDLE;
                        point <= 1'b0;
                    end
                end

                PULSE: begin
                    pending   <= pending_next;
                    score_bcd <= score_inc;
                    saturated <= (score_inc == SCORE_MAX);
                    if (score_inc > hi_bcd) begin
                        hi_bcd   <= score_inc;
                        new_high <= 1'b1;
                    end
                    state <= GAP;
                    point <= 1'b0;
                    busy  <= 1'b1;
                end

                GAP: begin
                    if (saturated) begin
                        pending <= '0;
                        state   <= IDLE;
                        point   <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        pending <= pending_next;
                        busy    <= (pending_next != '0);
                        if (pending_next != '0) begin
                            state <= PULSE;
                            point <= 1'b1;
                        end else begin
                            state <= IDLE;
                            point <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    point <= 1'b0;
                    busy  <= (pending != '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_award_sequencer.sv
// Self-checking bench for score_award_sequencer. A decimal, queue-free model
// of the award rules (pending points, one pulse every other cycle, 999 cap,
// high score) is advanced every cycle and compared against the DUT, with
// directed scenarios followed by randomized request traffic.
module tb_score_award_sequencer;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        point;
    logic        busy;
    logic [11:0] score_bcd;
    logic        saturated;
    logic [11:0] hi_bcd;
    logic        new_high;

    int total;
    int bad;

    score_award_sequencer_if #(.AMT_W(4)) aw ();

    score_award_sequencer #(.AMT_W(4), .PEND_W(8)) dut (
        .clk       (clk),
        .reset     (rst),
        .clear     (clr),
        .awards    (aw),
        .point     (point),
        .busy      (busy),
        .score_bcd (score_bcd),
        .saturated (saturated),
        .hi_bcd    (hi_bcd),
        .new_high  (new_high)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: values the registered outputs must show in the
    // current cycle. Scores are plain decimal integers.
    int m_pend;
    int m_score;
    int m_hi;
    bit m_nh;
    bit m_point;
    bit m_busy;
    bit model_valid;
    bit hack_seen;
    bit back_seen;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: on each falling edge check the DUT against the model,
    // predict this cycle's acks, then advance the model to the next cycle.
    always @(negedge clk) begin
        int  amt;
        int  acc;
        int  npend;
        bit  okf;
        bit  eh;
        bit  eb;
        bit  npt;
        hack_seen = aw.home_ack;
        back_seen = aw.bonus_ack;
        eh  = 1'b0;
        eb  = 1'b0;
        amt = aw.home_req ? int'(aw.home_amt) : int'(aw.bonus_amt);
        if (!rst && !clr) begin
            okf = (m_pend - int'(m_point) + amt) <= 255;
            eh  = aw.home_req && okf;
            eb  = !aw.home_req && aw.bonus_req && okf;
        end
        if (model_valid) begin
            checkOutput("point",     int'(point),     int'(m_point));
            checkOutput("busy",      int'(busy),      int'(m_busy));
            checkOutput("score_bcd", int'(score_bcd), int'(to_bcd(m_score)));
            checkOutput("saturated", int'(saturated), int'(m_score == 999));
            checkOutput("hi_bcd",    int'(hi_bcd),    int'(to_bcd(m_hi)));
            checkOutput("new_high",  int'(new_high),  int'(m_nh));
            checkOutput("home_ack",  int'(aw.home_ack),  int'(eh));
            checkOutput("bonus_ack", int'(aw.bonus_ack), int'(eb));
        end
        if (rst) begin
            m_pend = 0; m_score = 0; m_hi = 0; m_nh = 0;
            m_point = 0; m_busy = 0; model_valid = 1;
        end else if (clr) begin
            m_pend = 0; m_score = 0; m_nh = 0; m_point = 0; m_busy = 0;
        end else begin
            acc = ((eh || eb) && m_score != 999) ? amt : 0;
            if (m_point) begin
                npend = m_pend - 1 + acc;
                m_score++;
                if (m_score > m_hi) begin
                    m_hi = m_score;
                    m_nh = 1;
                end
                npt = 0;
            end else if (m_score == 999) begin
                npend = 0;
                npt   = 0;
            end else begin
                npend = m_pend + acc;
                npt   = (npend > 0);
            end
            m_busy  = m_point || npt || (npend != 0);
            m_point = npt;
            m_pend  = npend;
        end
    end

    // Advance one clock; a requester drops its level once it has been acked.
    task automatic step();
        @(posedge clk);
        #1;
        if (hack_seen) aw.home_req = 1'b0;
        if (back_seen) aw.bonus_req = 1'b0;
    endtask

    // Raise the selected requests and hold them until acked (bounded).
    task automatic applyStimulus(input bit useHome, input int ha,
                                 input bit useBonus, input int ba);
        int n;
        if (useHome) begin aw.home_req = 1'b1; aw.home_amt = 4'(ha); end
        if (useBonus) begin aw.bonus_req = 1'b1; aw.bonus_amt = 4'(ba); end
        n = 0;
        while ((aw.home_req || aw.bonus_req) && n < 600) begin
            step();
            n++;
        end
        if (aw.home_req || aw.bonus_req) begin
            total++; bad++;
            $display("[TB] FAIL ack_timeout: got no ack, expected ack within 600 cycles");
            aw.home_req = 1'b0; aw.bonus_req = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || aw.home_req || aw.bonus_req) && n < 3000) begin
            step();
            n++;
        end
        if (busy || aw.home_req || aw.bonus_req) begin
            total++; bad++;
            $display("[TB] FAIL idle_timeout: got busy=%0b, expected 0 within 3000 cycles", busy);
        end
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; model_valid = 0;
        rst = 1'b1; clr = 1'b0;
        aw.home_req = 1'b0; aw.home_amt = '0;
        aw.bonus_req = 1'b0; aw.bonus_amt = '0;
        step(); step();
        rst = 1'b0;
        checkOutput("lit_reset_score", int'(score_bcd), 0);
        checkOutput("lit_reset_busy",  int'(busy), 0);

        // Single award of 3 points.
        applyStimulus(1, 3, 0, 0);
        waitIdle();
        checkOutput("lit_award3", int'(score_bcd), 'h003);

        // Simultaneous home 5 and bonus 2.
        pulseClear();
        applyStimulus(1, 5, 1, 2);
        waitIdle();
        checkOutput("lit_both", int'(score_bcd), 'h007);

        // BCD carry out of the ones digit.
        pulseClear();
        applyStimulus(1, 9, 0, 0);
        waitIdle();
        applyStimulus(0, 0, 1, 2);
        waitIdle();
        checkOutput("lit_carry", int'(score_bcd), 'h011);

        // Climb to 997, then saturate at 999.
        pulseClear();
        for (int k = 0; k < 66; k++) applyStimulus(1, 15, 0, 0);
        applyStimulus(1, 7, 0, 0);
        waitIdle();
        checkOutput("lit_997", int'(score_bcd), 'h997);
        applyStimulus(0, 0, 1, 5);
        waitIdle();
        checkOutput("lit_999", int'(score_bcd), 'h999);
        checkOutput("lit_sat", int'(saturated), 1);
        applyStimulus(1, 4, 0, 0);
        waitIdle();
        checkOutput("lit_999_hold", int'(score_bcd), 'h999);

        // High score kept across a clear.
        rst = 1'b1; step(); rst = 1'b0;
        applyStimulus(1, 12, 0, 0);
        waitIdle();
        pulseClear();
        checkOutput("lit_hi_kept",  int'(hi_bcd), 'h012);
        checkOutput("lit_nh_clear", int'(new_high), 0);
        applyStimulus(0, 0, 1, 13);
        waitIdle();
        checkOutput("lit_hi_new", int'(hi_bcd), 'h013);
        checkOutput("lit_nh_set", int'(new_high), 1);

        // Saturate the pending accumulator, then abort the train with clear.
        pulseClear();
        for (int k = 0; k < 40; k++) begin
            if (!aw.bonus_req) begin
                aw.bonus_req = 1'b1;
                aw.bonus_amt = 4'd15;
            end
            step();
        end
        pulseClear();
        checkOutput("lit_abort_point", int'(point), 0);
        checkOutput("lit_abort_busy",  int'(busy), 0);
        waitIdle();

        // Randomized traffic with occasional new-game clears.
        for (int c = 0; c < 3000; c++) begin
            if (!aw.home_req && ($urandom % 4 == 0)) begin
                aw.home_req = 1'b1;
                aw.home_amt = 4'($urandom_range(0, 15));
            end
            if (!aw.bonus_req && ($urandom % 5 == 0)) begin
                aw.bonus_req = 1'b1;
                aw.bonus_amt = 4'($urandom_range(0, 15));
            end
            clr = ($urandom % 300 == 0);
            step();
        end
        clr = 1'b0;
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
